// File: rtl/hilo_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_md_unit
// Brief    : E-stage multiply/divide unit owning HI/LO, fixed-latency model
// Revision : 1.0 - initial release
// ============================================================================
module hilo_md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        req,
    input  logic        mf_sel,
    output logic        HILObusy,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    logic [3:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_valid;

    logic        w_issue;
    logic        w_is_md;
    logic        w_is_div;
    logic        w_signed;
    logic        w_div_zero;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_issue    = start && !req && (r_count == 4'd0);
    assign w_is_md    = !md_op[2];
    assign w_is_div   = w_is_md && md_op[1];
    assign w_signed   = !md_op[0];
    assign w_div_zero = (rt_val == 32'd0);

    assign HILObusy = (w_issue && w_is_md) || (r_count != 4'd0);
    assign md_out   = mf_sel ? r_hi : r_lo;
    assign hi       = r_hi;
    assign lo       = r_lo;

    // Low 64 bits of the product of sign/zero-extended operands are exact for both signednesses
    assign w_ext_a = {{32{w_signed & rs_val[31]}}, rs_val};
    assign w_ext_b = {{32{w_signed & rt_val[31]}}, rt_val};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed divide via magnitudes; avoids the INT_MIN / -1 overflow of native signed division
    always_comb begin
        w_abs_a = (w_signed && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
        w_abs_b = (w_signed && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
        if (w_div_zero) begin
            w_abs_b = 32'd1;
        end
        w_uq   = w_abs_a / w_abs_b;
        w_ur   = w_abs_a % w_abs_b;
        w_quot = w_uq;
        w_rem  = w_ur;
        if (w_signed && (rs_val[31] ^ rt_val[31])) begin
            w_quot = 32'd0 - w_uq;
        end
        if (w_signed && rs_val[31]) begin
            w_rem = 32'd0 - w_ur;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count      <= 4'd0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_pend_hi    <= 32'd0;
            r_pend_lo    <= 32'd0;
            r_pend_valid <= 1'b0;
        end else if (w_issue) begin
            case (md_op)
                3'd0, 3'd1: begin
                    r_pend_hi    <= w_prod[63:32];
                    r_pend_lo    <= w_prod[31:0];
                    r_pend_valid <= 1'b1;
                    r_count      <= c_mult_cnt;
                end
                3'd2, 3'd3: begin
                    r_pend_hi    <= w_rem;
                    r_pend_lo    <= w_quot;
                    r_pend_valid <= !w_div_zero;
                    r_count      <= c_div_cnt;
                end
                3'd4:    r_hi <= rs_val;
                3'd5:    r_lo <= rs_val;
                default: ;
            endcase
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
            if ((r_count == 4'd1) && r_pend_valid) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end
    end

    logic w_unused;
    assign w_unused = w_is_div;

endmodule
`default_nettype wire

// File: tb/tb_hilo_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_md_unit
// Brief    : Self-checking bench: directed plan plus random ops vs HI/LO model
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_md_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        req;
    logic        mf_sel;
    logic        HILObusy;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    hilo_md_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .req     (req),
        .mf_sel  (mf_sel),
        .HILObusy(HILObusy),
        .md_out  (md_out),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: architectural HI/LO plus the absolute cycle at which the result becomes visible
    longint      cyc = 0;
    longint      m_done = 0;
    logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
    logic        m_res_valid;
    bit          m_known = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%08h expected=%08h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_issue();
        return start && !req && !(cyc < m_done);
    endfunction

    task automatic model_check();
        logic exp_busy;
        if (!m_known) return;
        exp_busy = (model_issue() && md_op <= 3'd3) || (cyc < m_done);
        cmp("busy",   {31'd0, HILObusy}, {31'd0, exp_busy});
        cmp("hi",     hi, m_hi);
        cmp("lo",     lo, m_lo);
        cmp("md_out", md_out, mf_sel ? m_hi : m_lo);
    endtask

    task automatic model_edge();
        longint sa, sb, q, r;
        logic [63:0] up;
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_done = 0; m_res_valid = 0;
            m_known = 1;
        end else if (model_issue()) begin
            sa = longint'($signed(rs_val));
            sb = longint'($signed(rt_val));
            case (md_op)
                3'd0: begin
                    q = sa * sb;
                    m_res_hi = q[63:32]; m_res_lo = q[31:0]; m_res_valid = 1;
                    m_done = cyc + MULT_CYCLES + 1;
                end
                3'd1: begin
                    up = {32'd0, rs_val} * {32'd0, rt_val};
                    m_res_hi = up[63:32]; m_res_lo = up[31:0]; m_res_valid = 1;
                    m_done = cyc + MULT_CYCLES + 1;
                end
                3'd2: begin
                    m_res_valid = (rt_val != 0);
                    if (m_res_valid) begin
                        q = sa / sb; r = sa % sb;
                        m_res_lo = q[31:0]; m_res_hi = r[31:0];
                    end
                    m_done = cyc + DIV_CYCLES + 1;
                end
                3'd3: begin
                    m_res_valid = (rt_val != 0);
                    if (m_res_valid) begin
                        m_res_lo = rs_val / rt_val; m_res_hi = rs_val % rt_val;
                    end
                    m_done = cyc + DIV_CYCLES + 1;
                end
                3'd4: m_hi = rs_val;
                3'd5: m_lo = rs_val;
                default: ;
            endcase
        end else if (cyc + 1 == m_done && m_res_valid) begin
            m_hi = m_res_hi;
            m_lo = m_res_lo;
        end
    endtask

    task automatic set_idle();
        start = 0; md_op = 0; rs_val = 0; rt_val = 0; req = 0; reset = 1;
    endtask

    // One clock cycle: present inputs, compare at negedge, advance model at posedge
    task automatic cycle(input bit s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit rq, input bit rst_n, input bit sel);
        start = s; md_op = op; rs_val = a; rt_val = b; req = rq; reset = rst_n; mf_sel = sel;
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        set_idle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 3'd0, 0, 0, 0, 1, mf_sel);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        cycle(1, op, a, b, 0, 1, mf_sel);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        mf_sel = 0;
        set_idle();
        #1;
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cmp("rst_hi", hi, 32'h0);
        cmp("rst_lo", lo, 32'h0);
        cmp("rst_busy", {31'd0, HILObusy}, 32'h0);

        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        idle(4);
        cmp("mult_busy_c5", {31'd0, HILObusy}, 32'h1);
        idle(1);
        cmp("mult_busy_c6", {31'd0, HILObusy}, 32'h0);
        cmp("mult_hi", hi, 32'hFFFFFFFF);
        cmp("mult_lo", lo, 32'hFFFFFFFA);

        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        idle(5);
        cmp("multu_hi", hi, 32'h00000002);
        cmp("multu_lo", lo, 32'hFFFFFFFA);

        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        idle(10);
        cmp("div_lo", lo, 32'hFFFFFFFD);
        cmp("div_hi", hi, 32'hFFFFFFFF);

        issue(3'd3, 32'd7, 32'd0);
        idle(9);
        cmp("div0_busy_c10", {31'd0, HILObusy}, 32'h1);
        idle(1);
        cmp("div0_busy_c11", {31'd0, HILObusy}, 32'h0);
        cmp("div0_hi", hi, 32'hFFFFFFFF);
        cmp("div0_lo", lo, 32'hFFFFFFFD);

        start = 1; md_op = 3'd0; rs_val = 32'd9; rt_val = 32'd9; req = 1;
        #1;
        cmp("req_busy", {31'd0, HILObusy}, 32'h0);
        cycle(1, 3'd0, 32'd9, 32'd9, 1, 1, 0);
        idle(10);
        cmp("req_hi", hi, 32'hFFFFFFFF);
        cmp("req_lo", lo, 32'hFFFFFFFD);

        issue(3'd4, 32'h12345678, 32'd0);
        cmp("mthi_hi", hi, 32'h12345678);
        mf_sel = 1;
        #1;
        cmp("mthi_mdout", md_out, 32'h12345678);
        mf_sel = 0;

        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        idle(10);
        cmp("ovf_lo", lo, 32'h80000000);
        cmp("ovf_hi", hi, 32'h0);

        issue(3'd2, 32'd100, 32'd7);
        idle(3);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cmp("rstmid_busy", {31'd0, HILObusy}, 32'h0);
        cmp("rstmid_lo", lo, 32'h0);
        idle(10);
        cmp("rstmid_late_hi", hi, 32'h0);
        cmp("rstmid_late_lo", lo, 32'h0);

        issue(3'd0, 32'd6, 32'd7);
        idle(2);
        cycle(0, 0, 0, 0, 1, 1, 0);
        idle(2);
        cmp("reqmid_lo", lo, 32'd42);
        cmp("reqmid_hi", hi, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 5) == 0) rb = 32'hFFFFFFFF;
            rop = 3'($urandom_range(0, 7));
            cycle($urandom_range(0, 2) != 0, rop, ra, rb,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_md_unit.md
Name: hilo_md_unit

Overview:
- Execute-stage multiply/divide unit owning the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and produces the `HILObusy` flag consumed by the hazard stall logic, which holds any md/mt/mf instruction in D while busy.
- Models fixed multi-cycle latency with a down-counter.
- Honours the exception/interrupt request so an op in E is cancelled when an older instruction traps.

Parameters:
- MULT_CYCLES, 5, cycles after the issue cycle until a mult/multu result is committed to HI/LO (range 1..15).
- DIV_CYCLES, 10, cycles after the issue cycle until a div/divu result is committed to HI/LO (range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- start  input  1  E-stage instruction is an md/mt op this cycle.
- md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no effect).
- rs_val  input  32  forwarded rs operand (dividend / multiplicand / mt source).
- rt_val  input  32  forwarded rt operand (divisor / multiplier).
- req  input  1  exception/interrupt flush; cancels the op presented this cycle.
- mf_sel  input  1  0 selects LO, 1 selects HI onto md_out.
- HILObusy  output  1  unit busy; goes to the stall unit.
- md_out  output  32  combinational HI or LO for mfhi/mflo.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (reset==0 at a clock edge):
  - hi=0, lo=0, counter=0, pending results cleared.
  - HILObusy=0 the cycle after the reset edge.
  - Reset mid-operation discards the in-flight result.
- Issue acceptance: issue = start && !req && counter==0.
  - start while counter!=0 is ignored; the stall unit guarantees this does not happen.
  - req==1 suppresses the issue entirely: no state change, no busy.
- mult/multu/div/divu at the issue edge:
  - The 64-bit result is computed from rs_val/rt_val and latched into pend_hi/pend_lo.
  - counter loads MULT_CYCLES or DIV_CYCLES.
- Countdown:
  - Each later edge with counter!=0 decrements counter.
  - At the edge where counter goes 1->0, hi<=pend_hi and lo<=pend_lo.
  - The new HI/LO is visible in cycle issue+N+1.
- HILObusy = (issue && md_op<=3) || counter!=0. It is combinational on the start path, so busy is asserted in the issue cycle itself.
- mthi/mtlo at the issue edge:
  - hi<=rs_val (mthi) or lo<=rs_val (mtlo).
  - No busy asserted, counter unchanged.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
  - multu: unsigned 32x32 -> 64; same HI/LO split.
  - div: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned; lo = quotient, hi = remainder.
  - 0x80000000 / 0xFFFFFFFF (div): lo=0x80000000, hi=0.
  - Divide by zero: full DIV_CYCLES busy; hi/lo left unchanged at commit.
- req while counter!=0 does not abort: the in-flight op is older than the trapping instruction and completes normally.
- md_out = mf_sel ? hi : lo. It reflects the registers only, with no bypass of pending results; the stall guarantees mf is never issued while busy.
- Reserved md_op (6/7) with start: no state change, HILObusy=0.

Test Plan:
- Reset (reset=0 for 2 cycles), then release -> hi=lo=0, HILObusy=0.
- mult rs=0xFFFFFFFE, rt=3 issued at cycle 0 ->
  - HILObusy=1 for cycles 0..5, 0 at cycle 6.
  - Cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div rs=-7 (0xFFFFFFF9), rt=2 ->
  - HILObusy cycles 0..10.
  - Cycle 11: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu 7/0 -> busy 11 cycles, hi/lo unchanged.
- start=1, md_op=0, req=1 in the same cycle -> HILObusy=0 in that cycle; hi/lo/counter unchanged after 10 cycles.
- mthi rs=0x12345678 -> hi=0x12345678 next cycle, HILObusy never 1; mf_sel=1 -> md_out=0x12345678.
- div issued, reset=0 at cycle 4 -> from cycle 5: HILObusy=0, hi=lo=0, no later commit. Separately, req=1 at cycle 3 of a mult -> result still commits at cycle 6.
